// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - MM-stage load/store request bus between the pipeline and the SRAM controller
interface sram_ctrl_if;
   logic        mem_access_read;
   logic        mem_access_write;
   logic [31:0] mem_access_addr;
   logic [2:0]  mem_access_size;
   logic [31:0] mem_access_data_out;
   logic [31:0] mem_access_data_in;
   logic        stall;
   logic        addr_err;

   modport master (
      output mem_access_read, mem_access_write, mem_access_addr,
             mem_access_size, mem_access_data_out,
      input  mem_access_data_in, stall, addr_err
   );

   modport slave (
      input  mem_access_read, mem_access_write, mem_access_addr,
             mem_access_size, mem_access_data_out,
      output mem_access_data_in, stall, addr_err
   );
endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - fixed-wait-state async SRAM controller serving one MM load/store at a time
module sram_ctrl #(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   sram_ctrl_if.slave        mm,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_data_o,
   input  logic [31:0]       sram_data_i,
   output logic              sram_data_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   localparam logic [2:0] SIZE_BYTE       = 3'd0;
   localparam logic [2:0] SIZE_HALF       = 3'd1;
   localparam logic [2:0] SIZE_WORD       = 3'd2;
   localparam logic [2:0] SIZE_LEFT_WORD  = 3'd3;
   localparam logic [2:0] SIZE_RIGHT_WORD = 3'd4;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_d;
   logic [31:0]       data_o_d;
   logic              ce_n_d, oe_n_d, we_n_d, data_oe_d;
   logic [3:0]        be_n_d;

   logic              req;
   logic [1:0]        lane;
   logic [4:0]        left_mask;
   logic [3:0]        be_mask;
   logic              size_ok;
   logic              misaligned;
   logic              stall;
   logic              addr_err;

   // upper byte-address bits are beyond the SRAM and intentionally dropped
   logic unused_addr_bits;
   assign unused_addr_bits = ^mm.mem_access_addr[31:ADDR_W+2];

   assign req       = mm.mem_access_read | mm.mem_access_write;
   assign lane      = mm.mem_access_addr[1:0];
   assign left_mask = (5'd2 << lane) - 5'd1;

   // size/lane decode into active-high byte mask plus legality of the request
   always_comb begin
      be_mask    = 4'b0000;
      size_ok    = 1'b1;
      misaligned = 1'b0;
      case (mm.mem_access_size)
         SIZE_BYTE:       be_mask = 4'b0001 << lane;
         SIZE_HALF: begin
            be_mask    = mm.mem_access_addr[1] ? 4'b1100 : 4'b0011;
            misaligned = mm.mem_access_addr[0];
         end
         SIZE_WORD: begin
            be_mask    = 4'b1111;
            misaligned = (lane != 2'b00);
         end
         SIZE_LEFT_WORD:  be_mask = left_mask[3:0];
         SIZE_RIGHT_WORD: be_mask = 4'b1111 << lane;
         default:         size_ok = 1'b0;
      endcase
   end

   // next state, next registered SRAM pins and combinational stall/addr_err
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      rdata_d   = rdata_q;
      addr_d    = sram_addr;
      data_o_d  = sram_data_o;
      ce_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      data_oe_d = 1'b0;
      be_n_d    = 4'hF;
      stall     = 1'b0;
      addr_err  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (!size_ok || misaligned) begin
                  addr_err = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_d   = ACCESS;
                  cnt_d     = CNT_INIT;
                  wr_d      = mm.mem_access_write;
                  addr_d    = mm.mem_access_addr[ADDR_W+1:2];
                  if (mm.mem_access_write) begin
                     data_o_d = mm.mem_access_data_out;
                  end
                  ce_n_d    = 1'b0;
                  oe_n_d    = mm.mem_access_write;
                  // first ACCESS cycle is never the hold cycle since WAIT_STATES >= 2
                  we_n_d    = ~mm.mem_access_write;
                  data_oe_d = mm.mem_access_write;
                  be_n_d    = mm.mem_access_write ? ~be_mask : 4'b0000;
               end
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               if (!wr_q) begin
                  rdata_d = sram_data_i;
               end
            end else begin
               cnt_d     = cnt_q - 4'd1;
               ce_n_d    = 1'b0;
               oe_n_d    = sram_oe_n;
               // release we_n for the final ACCESS cycle to hold data/address
               we_n_d    = ~(wr_q && (cnt_q != 4'd1));
               data_oe_d = sram_data_oe;
               be_n_d    = sram_be_n;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rst) begin
         stall    = 1'b0;
         addr_err = 1'b0;
      end
   end

   // state and registered SRAM pins
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         wr_q         <= 1'b0;
         rdata_q      <= 32'd0;
         sram_addr    <= '0;
         sram_data_o  <= 32'd0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_data_oe <= 1'b0;
         sram_be_n    <= 4'hF;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         rdata_q      <= rdata_d;
         sram_addr    <= addr_d;
         sram_data_o  <= data_o_d;
         sram_ce_n    <= ce_n_d;
         sram_oe_n    <= oe_n_d;
         sram_we_n    <= we_n_d;
         sram_data_oe <= data_oe_d;
         sram_be_n    <= be_n_d;
      end
   end

   assign mm.mem_access_data_in = rdata_q;
   assign mm.stall              = stall;
   assign mm.addr_err           = addr_err;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - randomized bench for sram_ctrl against a cycle-timeline transaction model
module tb_sram_ctrl;
   localparam int W  = 2;
   localparam int AW = 20;

   localparam logic [2:0] SZ_BYTE  = 3'd0;
   localparam logic [2:0] SZ_HALF  = 3'd1;
   localparam logic [2:0] SZ_WORD  = 3'd2;
   localparam logic [2:0] SZ_LEFT  = 3'd3;
   localparam logic [2:0] SZ_RIGHT = 3'd4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_data_o;
   logic [31:0]   sram_data_i;
   logic          sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
   logic [3:0]    sram_be_n;

   sram_ctrl_if mm();

   sram_ctrl #(.WAIT_STATES(W), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .mm           (mm),
      .sram_addr    (sram_addr),
      .sram_data_o  (sram_data_o),
      .sram_data_i  (sram_data_i),
      .sram_data_oe (sram_data_oe),
      .sram_ce_n    (sram_ce_n),
      .sram_oe_n    (sram_oe_n),
      .sram_we_n    (sram_we_n),
      .sram_be_n    (sram_be_n)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: k is the cycle index within the current transaction (0 = request cycle), -1 when idle
   int          k = -1;
   logic        t_wr = 1'b0;
   logic [3:0]  t_mask = 4'h0;
   logic [31:0] t_addr = 32'd0, t_data = 32'd0, cap = 32'd0;
   logic [31:0] m_addr = 32'd0, m_dout = 32'd0, m_din = 32'd0;
   logic        prev_rst = 1'b1;
   logic        e_stall, e_err, e_ce_n, e_oe_n, e_we_n, e_doe;
   logic [3:0]  e_be_n;
   bit          chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // returns {legal, byte mask} from the byte-lane rules of each access size
   function automatic logic [4:0] decode(input logic [2:0] size, input logic [31:0] addr);
      logic [3:0] m;
      logic       ok;
      int         a;
      m  = 4'h0;
      ok = 1'b1;
      a  = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) begin
         case (size)
            SZ_BYTE:  m[i] = (i == a);
            SZ_HALF:  m[i] = ((i / 2) == int'(addr[1]));
            SZ_WORD:  m[i] = 1'b1;
            SZ_LEFT:  m[i] = (i <= a);
            SZ_RIGHT: m[i] = (i >= a);
            default:  ok = 1'b0;
         endcase
      end
      if (size == SZ_HALF && addr[0]) ok = 1'b0;
      if (size == SZ_WORD && addr[1:0] != 2'b00) ok = 1'b0;
      return {ok, m};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall",     mm.stall, e_stall);
         check("addr_err",  mm.addr_err, e_err);
         check("ce_n",      sram_ce_n, e_ce_n);
         check("oe_n",      sram_oe_n, e_oe_n);
         check("we_n",      sram_we_n, e_we_n);
         check("data_oe",   sram_data_oe, e_doe);
         check("be_n",      sram_be_n, e_be_n);
         check("sram_addr", sram_addr, m_addr);
         check("data_o",    sram_data_o, m_dout);
         check("data_in",   mm.mem_access_data_in, m_din);
      end
   end

   task automatic step(input logic r_rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] dout, input logic [31:0] sdi);
      logic [4:0] dec;
      logic       acc;
      @(posedge clk);
      #1;
      if (prev_rst) begin
         k = -1; m_addr = 32'd0; m_dout = 32'd0; m_din = 32'd0;
      end else if (k >= 0) begin
         k++;
         if (k == 1) begin
            m_addr = {{(32-AW){1'b0}}, t_addr[AW+1:2]};
            if (t_wr) m_dout = t_data;
         end
         if (k == W + 1 && !t_wr) m_din = cap;
         if (k > W + 1) k = -1;
      end
      rst                    = r_rst;
      mm.mem_access_read     = rd;
      mm.mem_access_write    = wr;
      mm.mem_access_addr     = addr;
      mm.mem_access_size     = size;
      mm.mem_access_data_out = dout;
      sram_data_i            = sdi;
      e_err = 1'b0;
      if (!r_rst && k < 0 && (rd || wr)) begin
         dec = decode(size, addr);
         if (dec[4]) begin
            k = 0; t_wr = wr; t_mask = dec[3:0]; t_addr = addr; t_data = dout;
         end else begin
            e_err = 1'b1;
         end
      end
      acc     = (k >= 1 && k <= W);
      e_stall = !r_rst && k >= 0 && k <= W;
      e_ce_n  = !acc;
      e_oe_n  = !(acc && !t_wr);
      e_we_n  = !(acc && t_wr && k < W);
      e_doe   = acc && t_wr;
      e_be_n  = acc ? (t_wr ? ~t_mask : 4'h0) : 4'hF;
      if (!r_rst && k == W && !t_wr) cap = sdi;
      prev_rst = r_rst;
      chk_en   = 1'b1;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'd0, SZ_WORD, 32'd0, 32'd0);
   endtask

   // one complete access with junk on the request lines after cycle 0, plus literal pins
   task automatic access(input string nm, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] dout, input logic [31:0] sdi,
                         input logic [3:0] lit_be, input int lit_we, input int lit_doe,
                         input int lit_oe, input logic [31:0] lit_addr,
                         input logic [31:0] lit_din);
      int         ns = 0, nwe = 0, ndoe = 0, noe = 0;
      logic [3:0] be1 = 4'h0, mbe1 = 4'h0;
      logic [31:0] a1 = 32'd0;
      for (int i = 0; i <= W + 1; i++) begin
         if (i == 0) step(1'b0, rd, wr, addr, size, dout, sdi);
         else step(1'b0, 1'($urandom), 1'($urandom), $urandom, 3'($urandom), $urandom, sdi);
         ns   += int'(mm.stall);
         nwe  += int'(!sram_we_n);
         ndoe += int'(sram_data_oe);
         noe  += int'(!sram_oe_n);
         if (i == 1) begin
            be1 = sram_be_n; mbe1 = e_be_n; a1 = 32'(sram_addr);
         end
      end
      check({nm, "_be"},        be1, lit_be);
      check({nm, "_model_be"},  mbe1, lit_be);
      check({nm, "_stall_cyc"}, ns, W + 1);
      check({nm, "_we_cyc"},    nwe, lit_we);
      check({nm, "_doe_cyc"},   ndoe, lit_doe);
      check({nm, "_oe_cyc"},    noe, lit_oe);
      check({nm, "_addr"},      a1, lit_addr);
      check({nm, "_din"},       mm.mem_access_data_in, lit_din);
      check({nm, "_model_din"}, m_din, lit_din);
      idle();
   endtask

   initial begin
      logic [2:0] sz;
      rst = 1'b1;
      mm.mem_access_read = 1'b1; mm.mem_access_write = 1'b1;
      mm.mem_access_addr = 32'h2; mm.mem_access_size = SZ_WORD;
      mm.mem_access_data_out = 32'd0; sram_data_i = 32'd0;
      @(posedge clk);

      // reset with requests held high
      repeat (3) begin
         step(1'b1, 1'b1, 1'b1, 32'h2, SZ_WORD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
         check("rst_stall", mm.stall, 1'b0);
         check("rst_ce_n", sram_ce_n, 1'b1);
         check("rst_din", mm.mem_access_data_in, 32'd0);
      end
      idle();

      access("rd_word", 1'b1, 1'b0, 32'h0000_0010, SZ_WORD, 32'd0, 32'hDEAD_BEEF,
             4'b0000, 0, 0, 2, 32'h4, 32'hDEAD_BEEF);
      access("st_byte", 1'b0, 1'b1, 32'h0000_0103, SZ_BYTE, 32'h5A5A_5A5A, 32'h0,
             4'b0111, 1, 2, 0, 32'h40, 32'hDEAD_BEEF);
      access("swl_a1", 1'b0, 1'b1, 32'h0000_0201, SZ_LEFT, 32'h1234_5678, 32'h0,
             4'b1100, 1, 2, 0, 32'h80, 32'hDEAD_BEEF);
      access("swr_a1", 1'b0, 1'b1, 32'h0000_0201, SZ_RIGHT, 32'h8765_4321, 32'h0,
             4'b0001, 1, 2, 0, 32'h80, 32'hDEAD_BEEF);
      access("st_half", 1'b1, 1'b1, 32'h0000_0302, SZ_HALF, 32'hA5A5_A5A5, 32'h0,
             4'b0011, 1, 2, 0, 32'hC0, 32'hDEAD_BEEF);

      // misaligned word load
      step(1'b0, 1'b1, 1'b0, 32'h0000_0012, SZ_WORD, 32'd0, 32'd0);
      check("mis_err", mm.addr_err, 1'b1);
      check("mis_stall", mm.stall, 1'b0);
      idle();
      check("mis_ce_n", sram_ce_n, 1'b1);
      check("mis_err_clr", mm.addr_err, 1'b0);

      // undefined size
      step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'd6, 32'd0, 32'd0);
      check("badsz_err", mm.addr_err, 1'b1);
      idle();
      check("badsz_ce_n", sram_ce_n, 1'b1);

      // reset in the second ACCESS cycle of a write
      step(1'b0, 1'b0, 1'b1, 32'h0000_0020, SZ_WORD, 32'h1122_3344, 32'd0);
      idle();
      step(1'b1, 1'b0, 1'b0, 32'd0, SZ_WORD, 32'd0, 32'd0);
      idle();
      check("rstmid_we_n", sram_we_n, 1'b1);
      check("rstmid_ce_n", sram_ce_n, 1'b1);
      check("rstmid_doe", sram_data_oe, 1'b0);
      check("rstmid_stall", mm.stall, 1'b0);
      access("rd_after_rst", 1'b1, 1'b0, 32'h0000_0024, SZ_WORD, 32'd0, 32'hCAFE_F00D,
             4'b0000, 0, 0, 2, 32'h9, 32'hCAFE_F00D);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         if ($urandom_range(0, 249) == 0)
            step(1'b1, 1'($urandom), 1'($urandom), $urandom, sz, $urandom, $urandom);
         else if (k >= 0 || $urandom_range(0, 2) == 0)
            step(1'b0, 1'($urandom), 1'($urandom), $urandom, sz, $urandom, $urandom);
         else
            step(1'b0, 1'b0, 1'b0, $urandom, sz, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
